// File: rtl/data_word_access_unit.sv
// Purpose : sequences one CPU word operation (load/store/bit RMW/saturating inc-dec) onto a single-port data memory.
// Latency : ACK 3 cycles after the REQ edge for LOAD, 2 for STORE, 4 for RMW, 1 for an illegal opcode.
// Backpres: one op in flight; REQ is only taken in IDLE or on the edge ending DONE, otherwise ignored.
module data_word_access_unit #(
   parameter int AW = 16,
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ,
   input  logic [2:0]    OP,
   input  logic [AW-1:0] ADDR,
   input  logic [DW-1:0] WDATA,
   input  logic [4:0]    BITSEL,
   output logic          BUSY,
   output logic          ACK,
   output logic          ERR,
   output logic [DW-1:0] RDATA,
   output logic [AW-1:0] M_A,
   output logic          M_WE,
   output logic [DW-1:0] M_DI,
   input  logic [DW-1:0] M_DQ
);

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_STORE = 3'd1;
   localparam logic [2:0] OP_SET   = 3'd2;
   localparam logic [2:0] OP_CLR   = 3'd3;
   localparam logic [2:0] OP_INC   = 3'd4;
   localparam logic [2:0] OP_DEC   = 3'd5;

   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

   state_t        state;
   logic [2:0]    op_q;
   logic [4:0]    bitsel_q;
   logic          accept;
   logic [DW-1:0] bit_mask;
   logic [DW-1:0] rmw_val;

   // A request is taken when idle, or back-to-back on the edge that closes DONE.
   assign accept = REQ && ((state == IDLE) || (state == DONE));

   // New word value for the read-modify-write ops, built from the word just read.
   always_comb begin
      bit_mask = ONE << bitsel_q;
      rmw_val  = M_DQ;
      case (op_q)
         OP_SET:  rmw_val = M_DQ | bit_mask;
         OP_CLR:  rmw_val = M_DQ & ~bit_mask;
         OP_INC:  rmw_val = (&M_DQ) ? M_DQ : (M_DQ + ONE);
         OP_DEC:  rmw_val = (|M_DQ) ? (M_DQ - ONE) : M_DQ;
         default: rmw_val = M_DQ;
      endcase
   end

   // Operation sequencer; every output is a register so the memory sees clean timing.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         op_q     <= OP_LOAD;
         bitsel_q <= '0;
         BUSY     <= 1'b0;
         ACK      <= 1'b0;
         ERR      <= 1'b0;
         RDATA    <= '0;
         M_A      <= '0;
         M_WE     <= 1'b0;
         M_DI     <= '0;
      end else if (accept) begin
         op_q     <= OP;
         bitsel_q <= BITSEL;
         BUSY     <= 1'b1;
         ACK      <= 1'b0;
         ERR      <= 1'b0;
         M_A      <= ADDR;
         M_WE     <= 1'b0;
         case (OP)
            OP_LOAD, OP_SET, OP_CLR, OP_INC, OP_DEC: begin
               state <= RD;
            end
            OP_STORE: begin
               state <= WR;
               M_WE  <= 1'b1;
               M_DI  <= WDATA;
            end
            default: begin
               // Illegal opcode: report immediately, never touch memory.
               state <= DONE;
               ACK   <= 1'b1;
               ERR   <= 1'b1;
            end
         endcase
      end else begin
         case (state)
            RD: begin
               // Memory registers M_A at the end of this cycle.
               state <= CAP;
            end
            CAP: begin
               if (op_q == OP_LOAD) begin
                  RDATA <= M_DQ;
                  ACK   <= 1'b1;
                  state <= DONE;
               end else begin
                  M_DI  <= rmw_val;
                  M_WE  <= 1'b1;
                  state <= WR;
               end
            end
            WR: begin
               // Memory writes at the edge closing this cycle; report the written value.
               M_WE  <= 1'b0;
               RDATA <= M_DI;
               ACK   <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               ACK   <= 1'b0;
               ERR   <= 1'b0;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_word_access_unit.sv
// Purpose : exercises data_word_access_unit against a behavioural memory and a word-level reference model.
// Latency : checks ACK timing per opcode relative to the REQ-sampling edge.
// Backpres: holds REQ through a busy op to confirm requests are not queued.
module tb_data_word_access_unit;

   localparam int AW = 16;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          REQ = 1'b0;
   logic [2:0]    OP = '0;
   logic [AW-1:0] ADDR = '0;
   logic [DW-1:0] WDATA = '0;
   logic [4:0]    BITSEL = '0;
   logic          BUSY;
   logic          ACK;
   logic          ERR;
   logic [DW-1:0] RDATA;
   logic [AW-1:0] M_A;
   logic          M_WE;
   logic [DW-1:0] M_DI;
   logic [DW-1:0] M_DQ;

   data_word_access_unit #(.AW(AW), .DW(DW)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .ADDR(ADDR), .WDATA(WDATA),
      .BITSEL(BITSEL), .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA),
      .M_A(M_A), .M_WE(M_WE), .M_DI(M_DI), .M_DQ(M_DQ)
   );

   always #5 CLK = ~CLK;

   // Single-port memory: synchronous write, registered read address, one-cycle read latency.
   logic [DW-1:0] mem [0:65535];
   logic [AW-1:0] rd_a;
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_a = '0;
   logic [DW-1:0] pl_d = '0;

   always @(posedge CLK) begin
      if (pl_en) mem[pl_a] <= pl_d;
      else if (M_WE) mem[M_A] <= M_DI;
      rd_a <= M_A;
   end
   assign M_DQ = mem[rd_a];

   // Write-strobe monitor.
   int            we_cnt = 0;
   logic [AW-1:0] we_addr = '0;
   always @(negedge CLK) begin
      if (M_WE === 1'b1) begin
         we_cnt++;
         we_addr = M_A;
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   logic [DW-1:0] ref_mem [0:15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Word-level meaning of each opcode.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] old,
                                         input logic [31:0] wd, input logic [4:0] bs);
      case (op)
         3'd1:    return wd;
         3'd2:    return old | (32'd1 << bs);
         3'd3:    return old & ~(32'd1 << bs);
         3'd4:    return (old == 32'hFFFF_FFFF) ? old : old + 32'd1;
         3'd5:    return (old == 32'd0) ? old : old - 32'd1;
         default: return old;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op);
      case (op)
         3'd0:                  return 3;
         3'd1:                  return 2;
         3'd2, 3'd3, 3'd4, 3'd5: return 4;
         default:               return 1;
      endcase
   endfunction

   task automatic preload(input int a, input logic [31:0] d);
      @(negedge CLK);
      pl_en = 1'b1; pl_a = AW'(a); pl_d = d;
      @(posedge CLK);
      #1 pl_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input int a,
                        input logic [31:0] wd, input logic [4:0] bs, input bit hold);
      int          lat;
      int          acks;
      int          we0;
      logic [31:0] exp;
      logic [31:0] rd_seen;
      logic        err_seen;
      bit          writes;
      exp = model(op, ref_mem[a], wd, bs);
      writes = (op >= 3'd1) && (op <= 3'd5);
      @(negedge CLK);
      OP = op; ADDR = AW'(a); WDATA = wd; BITSEL = bs; REQ = 1'b1;
      we0 = we_cnt;
      @(posedge CLK);
      lat = 0; acks = 0; rd_seen = '0; err_seen = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         if (!hold && c == 1) REQ = 1'b0;
         if (c == 1) chk({tag, "_busy"}, 32'(BUSY), 32'd1);
         if (ACK === 1'b1) begin
            acks++;
            if (lat == 0) begin
               lat = c; rd_seen = RDATA; err_seen = ERR;
            end
            REQ = 1'b0;
         end
      end
      REQ = 1'b0;
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(op)));
      chk({tag, "_acks"}, 32'(acks), 32'd1);
      chk({tag, "_err"}, 32'(err_seen), (op > 3'd5) ? 32'd1 : 32'd0);
      if (op <= 3'd5) chk({tag, "_rdata"}, rd_seen, exp);
      chk({tag, "_we"}, 32'(we_cnt - we0), writes ? 32'd1 : 32'd0);
      if (writes) begin
         chk({tag, "_we_addr"}, 32'(we_addr), 32'(a));
         ref_mem[a] = exp;
      end
      chk({tag, "_idle"}, 32'(BUSY), 32'd0);
   endtask

   initial begin
      int acks;
      int we0;
      // Reset values, asserted from time 0.
      #1;
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_ack", 32'(ACK), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_rdata", RDATA, 32'd0);
      chk("rst_ma", 32'(M_A), 32'd0);
      chk("rst_mwe", 32'(M_WE), 32'd0);
      chk("rst_mdi", M_DI, 32'd0);

      for (int i = 0; i < 16; i++) preload(i, $urandom);
      preload(0, 32'd500);
      preload(9, 32'h0000_00F5);
      preload(3, 32'd5);
      preload(4, 32'hFFFF_FFFF);
      preload(5, 32'd0);
      preload(2, 32'd1);
      @(negedge CLK);
      RST = 1'b0;

      // Directed cases.
      do_op("load0",   3'd0, 0, 32'd0, 5'd0, 1'b0);
      do_op("store7",  3'd1, 7, 32'hDEAD_BEEF, 5'd0, 1'b0);
      do_op("load7",   3'd0, 7, 32'd0, 5'd0, 1'b0);
      chk("load7_val", ref_mem[7], 32'hDEAD_BEEF);
      do_op("set9",    3'd2, 9, 32'd0, 5'd1, 1'b0);
      chk("mem9_set", mem[9], 32'h0000_00F7);
      do_op("clr9",    3'd3, 9, 32'd0, 5'd0, 1'b0);
      chk("mem9_clr", mem[9], 32'h0000_00F6);
      do_op("inc3",    3'd4, 3, 32'd0, 5'd0, 1'b0);
      chk("mem3_inc", mem[3], 32'd6);
      do_op("inc_sat", 3'd4, 4, 32'd0, 5'd0, 1'b0);
      chk("mem4_sat", mem[4], 32'hFFFF_FFFF);
      do_op("dec_sat", 3'd5, 5, 32'd0, 5'd0, 1'b0);
      chk("mem5_sat", mem[5], 32'd0);
      do_op("dec2",    3'd5, 2, 32'd0, 5'd0, 1'b0);
      chk("mem2_dec", mem[2], 32'd0);
      do_op("ill6",    3'd6, 1, 32'd0, 5'd0, 1'b0);
      do_op("hold_ld", 3'd0, 9, 32'd0, 5'd0, 1'b1);
      do_op("hold_inc", 3'd4, 6, 32'd0, 5'd0, 1'b1);

      // Reset in the RD cycle of an INC on address 3.
      @(negedge CLK);
      OP = 3'd4; ADDR = 16'd3; REQ = 1'b1;
      we0 = we_cnt;
      @(posedge CLK);
      @(negedge CLK);
      REQ = 1'b0;
      #1 RST = 1'b1;
      #1;
      chk("ab_busy", 32'(BUSY), 32'd0);
      chk("ab_ack", 32'(ACK), 32'd0);
      chk("ab_mwe", 32'(M_WE), 32'd0);
      chk("ab_ma", 32'(M_A), 32'd0);
      chk("ab_rdata", RDATA, 32'd0);
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      acks = 0;
      repeat (6) begin
         @(negedge CLK);
         if (ACK === 1'b1) acks++;
      end
      chk("ab_no_ack", 32'(acks), 32'd0);
      chk("ab_no_we", 32'(we_cnt - we0), 32'd0);
      chk("ab_mem3", mem[3], ref_mem[3]);
      do_op("post_rst", 3'd4, 3, 32'd0, 5'd0, 1'b0);

      // Randomized operations against the reference model.
      for (int n = 0; n < 40; n++) begin
         do_op("rnd", 3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
               $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
